spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Consumes the byte stream from the SPI slave receiver (byte + one-cycle ready strobe + frame-active level) and parses it into commands.
- Register-write commands produce a one-cycle write strobe to the config register file.
- Stream commands pack byte pairs into 16-bit pixel words for the framebuffer/overlay writer.
- Sits between the SPI slave and the config/overlay stages, in the single `clk` domain.

Parameters:
- ADDR_W, 4, register address width; taken from the opcode byte low nibble, so ADDR_W <= 4.
- PX_CNT_W, 20, width of the per-frame pixel counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- byte_in  in  8  received byte; valid only when byte_valid=1
- byte_valid  in  1  one-cycle strobe, new byte on byte_in
- spi_active  in  1  high while the SPI frame is active (slave select asserted)
- reg_wr_en  out  1  one-cycle register write strobe
- reg_addr  out  ADDR_W  register address, held until the next write
- reg_wdata  out  16  register data, held until the next write
- px_valid  out  1  one-cycle pixel strobe
- px_data  out  16  pixel word, held until the next pixel
- px_count  out  PX_CNT_W  pixels emitted in the current stream command
- err_count  out  8  protocol error counter, saturating
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0.
- Opcode byte: bits [7:4] are the command, bits [3:0] are the address.
  - 0x0 NOP.
  - 0x1 WRITE_REG.
  - 0x2 STREAM.
  - Others are illegal.
- States: IDLE, WR_HI, WR_LO, WR_CHK (feature only), ST_HI, ST_LO, DISCARD.
- byte_valid is ignored while spi_active=0.
- Frame end:
  - Any cycle with spi_active=0 forces state=IDLE on the next edge.
  - Frame end has priority over a coincident byte_valid.
  - Partial commands are dropped without a write.
- IDLE, on byte_valid:
  - cmd 0x0: stay in IDLE.
  - cmd 0x1: latch address (low ADDR_W bits), go to WR_HI.
  - cmd 0x2: clear px_count to 0, go to ST_HI.
  - Illegal cmd: err_count+1, go to DISCARD.
- WR_HI: on byte, latch data[15:8], go to WR_LO.
- WR_LO: on byte, go to IDLE.
  - Next cycle: reg_wr_en=1, with reg_wdata and reg_addr updated in the same cycle.
  - Latency: the strobe is 1 clk after the last byte's byte_valid.
- Several commands are allowed back-to-back in one frame; after a write, the next byte is a new opcode.
- ST_HI: on byte, latch the high byte, go to ST_LO.
- ST_LO: on byte, go to ST_HI. The next cycle gives:
  - px_valid=1
  - px_data={hi,lo}
  - px_count+1, wrapping at 2^PX_CNT_W
- STREAM consumes the remainder of the frame; it has no in-band terminator.
- Frame end while in ST_LO (odd byte count): err_count+1; the half pixel is discarded.
- Frame end during WR_HI/WR_LO/WR_CHK: err_count+1; no write.
- DISCARD: ignore all bytes until frame end.
- err_count saturates at 255 and is cleared only by rst.
- A mid-operation rst aborts immediately; px_count=0.
- reg_wr_en and px_valid are never high in the same cycle and never high for more than one cycle per command.

Optional Feature:
- Macro: SPI_CMD_CHECKSUM_EN
- Defined:
  - WR_LO goes to WR_CHK instead of IDLE.
  - The WR_CHK byte must equal opcode^hi^lo.
  - Match: reg_wr_en pulses 1 clk after the checksum byte; state=IDLE.
  - Mismatch: no write; err_count+1; state=IDLE.
  - STREAM is unaffected.
- Undefined: WR_CHK is absent; the write fires after the low data byte as described above.

Test Plan:
- Frame 0x13,0xAB,0xCD (no macro) -> single reg_wr_en pulse, reg_addr=3, reg_wdata=0xABCD, 1 clk after 3rd byte_valid; err_count=0.
- Frame 0x21,0x10,0x00,0xFF,0xFF -> px_valid twice; px_data 0x1000 then 0xFFFF; px_count=2.
- Frame 0x20,0x12,0x34,0x56 then spi_active=0 -> one pixel 0x1234; err_count=1; state IDLE; busy=0.
- Frame 0x70,0x11,0x12 -> no strobes; err_count=1.
- One frame 0x00,0x15,0x00,0x01,0x16,0x00,0x02 -> two writes: (5,0x0001) then (6,0x0002).
- rst during WR_LO -> all outputs 0 asynchronously.
- 256 illegal frames -> err_count holds at 255.
- With SPI_CMD_CHECKSUM_EN: 0x13,0xAB,0xCD,0x75 -> write occurs; same with 0x00 as 4th byte -> no write, err_count+1.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI byte-stream command decoder: register writes and 16-bit pixel streaming.
// Define SPI_CMD_CHECKSUM_EN to require an XOR checksum byte after each register write.
module spi_cmd_decoder #(
  parameter int ADDR_W   = 4,
  parameter int PX_CNT_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  input  logic                spi_active,
  output logic                reg_wr_en,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [15:0]         reg_wdata,
  output logic                px_valid,
  output logic [15:0]         px_data,
  output logic [PX_CNT_W-1:0] px_count,
  output logic [7:0]          err_count,
  output logic                busy
);

`ifdef SPI_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, WR_CHK, ST_HI, ST_LO, DISCARD} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, ST_HI, ST_LO, DISCARD} state_t;
`endif

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_WRITE  = 4'h1;
  localparam logic [3:0] CMD_STREAM = 4'h2;
  localparam logic [PX_CNT_W-1:0] PX_ONE = PX_CNT_W'(1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            hi_q, hi_d;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]            opc_q, opc_d;
  logic [7:0]            lo_q, lo_d;
`endif
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  pxv_q, pxv_d;
  logic [15:0]           pxd_q, pxd_d;
  logic [PX_CNT_W-1:0]   pxc_q, pxc_d;
  logic [7:0]            err_q, err_d;
  logic                  err_inc;
  logic                  frame_end_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      opc_q   <= '0;
      lo_q    <= '0;
`endif
      wr_en_q <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
      pxv_q   <= 1'b0;
      pxd_q   <= '0;
      pxc_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
`ifdef SPI_CMD_CHECKSUM_EN
      opc_q   <= opc_d;
      lo_q    <= lo_d;
`endif
      wr_en_q <= wr_en_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      pxv_q   <= pxv_d;
      pxd_q   <= pxd_d;
      pxc_q   <= pxc_d;
      err_q   <= err_d;
    end
  end

  // A frame that ends mid-write or on half a pixel is a protocol error.
  always_comb begin
    frame_end_err = 1'b0;
    case (state_q)
      WR_HI, WR_LO, ST_LO: frame_end_err = 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
      WR_CHK:              frame_end_err = 1'b1;
`endif
      default:             frame_end_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
`ifdef SPI_CMD_CHECKSUM_EN
    opc_d   = opc_q;
    lo_d    = lo_q;
`endif
    wr_en_d = 1'b0;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    pxv_d   = 1'b0;
    pxd_d   = pxd_q;
    pxc_d   = pxc_q;
    err_inc = 1'b0;

    // Frame end outranks any byte arriving in the same cycle.
    if (!spi_active) begin
      state_d = IDLE;
      err_inc = frame_end_err;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          case (byte_in[7:4])
            CMD_NOP: state_d = IDLE;
            CMD_WRITE: begin
              addr_d  = byte_in[ADDR_W-1:0];
`ifdef SPI_CMD_CHECKSUM_EN
              opc_d   = byte_in;
`endif
              state_d = WR_HI;
            end
            CMD_STREAM: begin
              pxc_d   = '0;
              state_d = ST_HI;
            end
            default: begin
              err_inc = 1'b1;
              state_d = DISCARD;
            end
          endcase
        end
        WR_HI: begin
          hi_d    = byte_in;
          state_d = WR_LO;
        end
        WR_LO: begin
`ifdef SPI_CMD_CHECKSUM_EN
          lo_d    = byte_in;
          state_d = WR_CHK;
`else
          wr_en_d = 1'b1;
          raddr_d = addr_q;
          wdata_d = {hi_q, byte_in};
          state_d = IDLE;
`endif
        end
`ifdef SPI_CMD_CHECKSUM_EN
        WR_CHK: begin
          if (byte_in == (opc_q ^ hi_q ^ lo_q)) begin
            wr_en_d = 1'b1;
            raddr_d = addr_q;
            wdata_d = {hi_q, lo_q};
          end else begin
            err_inc = 1'b1;
          end
          state_d = IDLE;
        end
`endif
        ST_HI: begin
          hi_d    = byte_in;
          state_d = ST_LO;
        end
        ST_LO: begin
          pxv_d   = 1'b1;
          pxd_d   = {hi_q, byte_in};
          pxc_d   = pxc_q + PX_ONE;
          state_d = ST_HI;
        end
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase
    end

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  assign reg_wr_en = wr_en_q;
  assign reg_addr  = raddr_q;
  assign reg_wdata = wdata_q;
  assign px_valid  = pxv_q;
  assign px_data   = pxd_q;
  assign px_count  = pxc_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames plus random frames
// checked against a frame-level parser model.
module tb_spi_cmd_decoder;
  localparam int ADDR_W   = 4;
  localparam int PX_CNT_W = 20;
`ifdef SPI_CMD_CHECKSUM_EN
  localparam int WR_LEN = 4;
`else
  localparam int WR_LEN = 3;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                spi_active;
  logic                reg_wr_en;
  logic [ADDR_W-1:0]   reg_addr;
  logic [15:0]         reg_wdata;
  logic                px_valid;
  logic [15:0]         px_data;
  logic [PX_CNT_W-1:0] px_count;
  logic [7:0]          err_count;
  logic                busy;

  spi_cmd_decoder #(.ADDR_W(ADDR_W), .PX_CNT_W(PX_CNT_W)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .spi_active(spi_active), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .px_valid(px_valid), .px_data(px_data),
    .px_count(px_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_px;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned cyc;
  } obs_t;

  typedef struct {
    bit          is_px;
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
  } exp_t;

  obs_t        obs_q[$];
  exp_t        exp_q[$];
  int unsigned both_hi = 0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    obs_t o;
    if (reg_wr_en && px_valid) both_hi++;
    if (reg_wr_en) begin
      o.is_px = 1'b0; o.a = 32'(reg_addr); o.d = 32'(reg_wdata); o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (px_valid) begin
      o.is_px = 1'b1; o.a = 32'(px_count); o.d = 32'(px_data); o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference model: parses a complete received byte list.
  logic [7:0]          frame[$];
  logic [7:0]          mframe[$];
  int                  m_err = 0;
  logic [PX_CNT_W-1:0] m_cnt = '0;

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic push_exp(input bit is_px, input logic [31:0] a, input logic [31:0] d, input int idx);
    exp_t e;
    e.is_px = is_px; e.a = a; e.d = d; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic model_frame();
    int i = 0;
    int n = mframe.size();
    bit done = 0;
    while (i < n && !done) begin
      int cmd;
      cmd = int'(mframe[i]) / 16;
      if (cmd == 0) begin
        i++;
      end else if (cmd == 1) begin
        if (i + WR_LEN > n) begin
          bump_err(); done = 1;
        end else begin
`ifdef SPI_CMD_CHECKSUM_EN
          if (mframe[i+3] != (mframe[i] ^ mframe[i+1] ^ mframe[i+2])) bump_err();
          else
`endif
          push_exp(0, 32'(int'(mframe[i]) % (1 << ADDR_W)),
                   32'(int'(mframe[i+1]) * 256 + int'(mframe[i+2])), i + WR_LEN - 1);
          i += WR_LEN;
        end
      end else if (cmd == 2) begin
        int k;
        m_cnt = '0;
        k = i + 1;
        while (k + 1 < n) begin
          m_cnt = m_cnt + 1'b1;
          push_exp(1, 32'(m_cnt), 32'(int'(mframe[k]) * 256 + int'(mframe[k+1])), k + 1);
          k += 2;
        end
        if (k < n) bump_err();
        done = 1;
      end else begin
        bump_err(); done = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sends the frame with random gaps; with cut set, the last byte coincides with frame end.
  task automatic run_frame(input bit cut);
    int unsigned bcyc[$];
    int n = frame.size();
    obs_q.delete(); exp_q.delete(); both_hi = 0;
    spi_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      byte_in = frame[i]; byte_valid = 1'b1;
      if (cut && i == n - 1) spi_active = 1'b0;
      bcyc.push_back(cyc);
      tick();
      byte_valid = 1'b0; byte_in = 8'($urandom);
    end
    if (!cut) begin
      repeat ($urandom_range(0, 2)) tick();
      spi_active = 1'b0;
      tick();
    end
    byte_in = 8'h20; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    repeat (3) tick();

    mframe = frame;
    if (cut) void'(mframe.pop_back());
    model_frame();

    chk("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int e = 0; e < exp_q.size() && e < obs_q.size(); e++) begin
      chk("event_kind", 32'(obs_q[e].is_px), 32'(exp_q[e].is_px));
      chk(exp_q[e].is_px ? "px_count_at_strobe" : "reg_addr_at_strobe", obs_q[e].a, exp_q[e].a);
      chk(exp_q[e].is_px ? "px_data_at_strobe" : "reg_wdata_at_strobe", obs_q[e].d, exp_q[e].d);
      chk("strobe_cycle", 32'(obs_q[e].cyc), 32'(bcyc[exp_q[e].idx] + 1));
    end
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("px_count_held", 32'(px_count), 32'(m_cnt));
    chk("busy_after_frame", 32'(busy), 32'(0));
    chk("strobe_overlap", 32'(both_hi), 32'(0));
  endtask

  task automatic gen_frame(output bit cut);
    int  ncmd;
    bit  stop;
    int  keep;
    ncmd = $urandom_range(1, 3);
    stop = 0;
    frame.delete();
    for (int c = 0; c < ncmd && !stop; c++) begin
      int unsigned r;
      logic [7:0] op, h, l;
      r = $urandom_range(0, 3);
      case (r)
        0: frame.push_back({4'h0, 4'($urandom)});
        1: begin
          op = {4'h1, 4'($urandom)}; h = 8'($urandom); l = 8'($urandom);
          frame.push_back(op); frame.push_back(h); frame.push_back(l);
`ifdef SPI_CMD_CHECKSUM_EN
          frame.push_back(($urandom_range(0, 3) != 0) ? (op ^ h ^ l) : 8'($urandom));
`endif
        end
        2: begin
          frame.push_back({4'h2, 4'($urandom)});
          repeat ($urandom_range(0, 7)) frame.push_back(8'($urandom));
          stop = 1;
        end
        default: begin
          frame.push_back({4'($urandom_range(3, 15)), 4'($urandom)});
          repeat ($urandom_range(0, 3)) frame.push_back(8'($urandom));
          stop = 1;
        end
      endcase
    end
    if ($urandom_range(0, 3) == 0) begin
      keep = $urandom_range(1, frame.size());
      while (frame.size() > keep) void'(frame.pop_back());
    end
    cut = (frame.size() > 1) && ($urandom_range(0, 4) == 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg_wr_en"}, 32'(reg_wr_en), 32'(0));
    chk({tag, "_reg_addr"},  32'(reg_addr),  32'(0));
    chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'(0));
    chk({tag, "_px_valid"},  32'(px_valid),  32'(0));
    chk({tag, "_px_data"},   32'(px_data),   32'(0));
    chk({tag, "_px_count"},  32'(px_count),  32'(0));
    chk({tag, "_err_count"}, 32'(err_count), 32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
  endtask

  initial begin
    bit cut;
    rst = 1'b1; byte_in = '0; byte_valid = 1'b0; spi_active = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

`ifdef SPI_CMD_CHECKSUM_EN
    frame = '{8'h13, 8'hAB, 8'hCD, 8'h75};
    run_frame(0);
    chk("chk_ok_addr", 32'(reg_addr), 32'h3);
    chk("chk_ok_wdata", 32'(reg_wdata), 32'hABCD);
    chk("chk_ok_err", 32'(err_count), 32'd0);
    frame = '{8'h13, 8'hAB, 8'hCD, 8'h00};
    run_frame(0);
    chk("chk_bad_err", 32'(err_count), 32'd1);
`else
    frame = '{8'h13, 8'hAB, 8'hCD};
    run_frame(0);
    chk("wr_addr", 32'(reg_addr), 32'h3);
    chk("wr_wdata", 32'(reg_wdata), 32'hABCD);
    chk("wr_err", 32'(err_count), 32'd0);
    frame = '{8'h00, 8'h15, 8'h00, 8'h01, 8'h16, 8'h00, 8'h02};
    run_frame(0);
    chk("b2b_writes", 32'(exp_q.size()), 32'd2);
    chk("b2b_last_addr", 32'(reg_addr), 32'h6);
    chk("b2b_last_wdata", 32'(reg_wdata), 32'h0002);
`endif
    frame = '{8'h21, 8'h10, 8'h00, 8'hFF, 8'hFF};
    run_frame(0);
    chk("stream_px_count", 32'(px_count), 32'd2);
    chk("stream_px_data", 32'(px_data), 32'hFFFF);
    frame = '{8'h20, 8'h12, 8'h34, 8'h56};
    run_frame(0);
    chk("odd_px_data", 32'(px_data), 32'h1234);
    chk("odd_px_count", 32'(px_count), 32'd1);
    frame = '{8'h70, 8'h11, 8'h12};
    run_frame(0);

    for (int f = 0; f < 60; f++) begin
      gen_frame(cut);
      run_frame(cut);
    end

    for (int f = 0; f < 260; f++) begin
      frame = '{8'h00};
      frame[0] = {4'($urandom_range(3, 15)), 4'($urandom)};
      run_frame(0);
    end
    chk("err_saturated", 32'(err_count), 32'd255);

    // Asynchronous reset in the middle of a register write.
    spi_active = 1'b1;
    tick();
    byte_in = 8'h13; byte_valid = 1'b1; tick();
    byte_in = 8'hAB; tick();
    byte_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    tick();
    rst = 1'b0; spi_active = 1'b0;
    m_err = 0; m_cnt = '0;
    tick();

    for (int f = 0; f < 10; f++) begin
      gen_frame(cut);
      run_frame(cut);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
